// File: rtl/conbus_csrbrg_if.sv
// Wishbone classic slave-side signal bundle for the CSR bridge.
interface conbus_csrbrg_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/conbus_csrbrg.sv
// Wishbone-to-CSR bridge: single-cycle CSR accesses from 32-bit Wishbone classic cycles.
// Define CONBUS_CSRBRG_RDATA_REG_EN to retime read data through a capture register.
module conbus_csrbrg (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    conbus_csrbrg_if.slave        wb,
    output logic [13:0]           csr_a,
    output logic                  csr_we,
    output logic [31:0]           csr_do,
    input  logic [31:0]           csr_di
);

    typedef enum logic [2:0] {
        StIdle,
        StWack,
        StRwait,
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
        StRcap,
`endif
        StRack
    } state_e;

    state_e state_q, state_d;

    logic        ack_q, ack_d;
    logic        we_q, we_d;
    logic [13:0] csr_a_q, csr_a_d;
    logic [31:0] csr_do_q, csr_do_d;
    logic        req;
    logic        unused_adr;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign unused_adr = ^{wb.wb_adr_i[31:16], wb.wb_adr_i[1:0]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping cyc before the ack is scheduled abandons the read so no stale ack escapes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req) state_d = wb.wb_we_i ? StWack : StRwait;
            StWack:  state_d = StIdle;
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
            StRwait: state_d = wb.wb_cyc_i ? StRcap : StIdle;
            StRcap:  state_d = wb.wb_cyc_i ? StRack : StIdle;
`else
            StRwait: state_d = wb.wb_cyc_i ? StRack : StIdle;
`endif
            StRack:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef CONBUS_CSRBRG_RDATA_REG_EN
    logic [31:0] rdata_q, rdata_d;
`endif

    always_comb begin
        ack_d    = 1'b0;
        we_d     = 1'b0;
        csr_a_d  = csr_a_q;
        csr_do_d = csr_do_q;
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
        rdata_d  = rdata_q;
`endif
        case (state_q)
            StIdle: begin
                if (req) begin
                    csr_a_d  = wb.wb_adr_i[15:2];
                    csr_do_d = wb.wb_dat_i;
                    if (wb.wb_we_i) begin
                        we_d  = 1'b1;
                        ack_d = 1'b1;
                    end
                end
            end
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
            StRcap: begin
                rdata_d = csr_di;
                ack_d   = wb.wb_cyc_i;
            end
`else
            StRwait: ack_d = wb.wb_cyc_i;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack_q    <= 1'b0;
            we_q     <= 1'b0;
            csr_a_q  <= '0;
            csr_do_q <= '0;
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
            rdata_q  <= '0;
`endif
        end else begin
            ack_q    <= ack_d;
            we_q     <= we_d;
            csr_a_q  <= csr_a_d;
            csr_do_q <= csr_do_d;
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
            rdata_q  <= rdata_d;
`endif
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign csr_we      = we_q;
    assign csr_a       = csr_a_q;
    assign csr_do      = csr_do_q;

    // StRack is only reached by reads, so it doubles as the read-ack qualifier.
`ifdef CONBUS_CSRBRG_RDATA_REG_EN
    assign wb.wb_dat_o = (state_q == StRack) ? rdata_q : '0;
`else
    assign wb.wb_dat_o = (state_q == StRack) ? csr_di : '0;
`endif

endmodule

// File: tb/tb_conbus_csrbrg.sv
// Directed bench for conbus_csrbrg with a registered CSR slave model and read scoreboard.
module tb_conbus_csrbrg;

`ifdef CONBUS_CSRBRG_RDATA_REG_EN
    localparam int RdLat = 3;
`else
    localparam int RdLat = 2;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di;

    conbus_csrbrg_if bus ();

    conbus_csrbrg dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb      (bus),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .csr_di  (csr_di)
    );

    always #5 sys_clk = ~sys_clk;

    // Registered CSR slave: unwritten words read back a pattern derived from the address.
    bit [31:0] slave_mem [64];
    bit [63:0] slave_vld;
    always @(posedge sys_clk) begin
        if (csr_we === 1'b1) begin
            slave_mem[csr_a[5:0]] <= csr_do;
            slave_vld[csr_a[5:0]] <= 1'b1;
        end
        csr_di <= slave_vld[csr_a[5:0]] ? slave_mem[csr_a[5:0]]
                                        : (32'hA500_0000 | {18'd0, csr_a});
    end

    int we_pulses = 0;
    always @(posedge sys_clk) if (csr_we === 1'b1) we_pulses <= we_pulses + 1;

    int          checks = 0;
    int          errors = 0;
    int          n_writes = 0;
    logic [31:0] exp_q[$];
    bit   [31:0] sh_mem[int];

    function automatic logic [31:0] model_rd(input logic [13:0] a);
        if (sh_mem.exists(int'(a))) return sh_mem[int'(a)];
        return 32'hA500_0000 | {18'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ack"}, 32'(bus.wb_ack_o), 0);
        check({tag, ".dat_o"}, bus.wb_dat_o, 0);
        check({tag, ".we"}, 32'(csr_we), 0);
        check({tag, ".a"}, 32'(csr_a), 0);
        check({tag, ".do"}, csr_do, 0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input bit hold);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        tick();  // T1
        check({tag, ".ack"}, 32'(bus.wb_ack_o), 1);
        check({tag, ".we"}, 32'(csr_we), 1);
        check({tag, ".a"}, 32'(csr_a), 32'(adr[15:2]));
        check({tag, ".do"}, csr_do, dat);
        check({tag, ".dat_o"}, bus.wb_dat_o, 0);
        if (!hold) idle_bus();
        sh_mem[int'(adr[15:2])] = dat;
        n_writes++;
        tick();  // T2
        if (hold) idle_bus();
        check({tag, ".we_off"}, 32'(csr_we), 0);
        check({tag, ".ack_off"}, 32'(bus.wb_ack_o), 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr);
        int n;
        bit got;
        exp_q.push_back(model_rd(adr[15:2]));
        bus.wb_adr_i = adr;
        bus.wb_dat_i = $urandom;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 6 && !got; i++) begin
            tick();
            if (i == 1) check({tag, ".a"}, 32'(csr_a), 32'(adr[15:2]));
            if (bus.wb_ack_o === 1'b1) begin
                got = 1'b1;
                n   = i;
                idle_bus();
            end else begin
                check({tag, ".dat_o_idle"}, bus.wb_dat_o, 0);
            end
        end
        check({tag, ".acked"}, 32'(got), 1);
        check({tag, ".lat"}, n, RdLat);
        if (got && exp_q.size() > 0) check({tag, ".data"}, bus.wb_dat_o, exp_q.pop_front());
        idle_bus();
        tick();
        check({tag, ".ack_off"}, 32'(bus.wb_ack_o), 0);
        check({tag, ".dat_o_off"}, bus.wb_dat_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_bus();
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wb_adr_i = $urandom;
            bus.wb_dat_i = $urandom;
            bus.wb_we_i  = 1'($urandom);
            bus.wb_cyc_i = 1'($urandom);
            bus.wb_stb_i = 1'($urandom);
            tick();
            check_zero("reset");
        end
        sys_rst = 1'b0;
        idle_bus();
        tick();
        check("post_reset.ack", 32'(bus.wb_ack_o), 0);

        do_write("wr1", 32'h0000_0124, 32'hDEAD_BEEF, 1'b0);
        do_write("wr_pre", 32'h0000_0008, 32'h1234_5678, 1'b0);
        do_read("rd1", 32'h0000_0008);
        do_read("rd_dflt", 32'h0000_0030);

        // Back-to-back: each access driven in the cycle right after the previous ack.
        do_write("b2b_wr1", 32'h0000_0040, 32'hCAFE_F00D, 1'b0);
        do_read("b2b_rd", 32'h0000_0040);
        do_write("b2b_wr2", 32'h0000_0044, 32'h0BAD_F00D, 1'b0);
        do_read("b2b_rd2", 32'h0000_0044);

        do_write("wr_hold", 32'h0000_0050, 32'h5555_AAAA, 1'b1);
        do_read("rd_hold", 32'h0000_0050);

        // Abort: cyc dropped in T1 of a read.
        bus.wb_adr_i = 32'h0000_0010;
        bus.wb_dat_i = 32'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        tick();
        check("abort.a", 32'(csr_a), 32'h004);
        check("abort.ack_t1", 32'(bus.wb_ack_o), 0);
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort.no_ack", 32'(bus.wb_ack_o), 0);
        end
        do_write("wr_after_abort", 32'h0000_0014, 32'h7777_0001, 1'b0);

        // Reset pulsed while the read sits in RWAIT.
        bus.wb_adr_i = 32'h0000_0020;
        bus.wb_dat_i = 32'hF0F0_1234;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        tick();
        check("rst_mid.do", csr_do, 32'hF0F0_1234);
        sys_rst = 1'b1;
        idle_bus();
        tick();
        check_zero("rst_mid");
        sys_rst = 1'b0;
        tick();
        check("rst_mid.ack_after", 32'(bus.wb_ack_o), 0);
        do_read("rd_after_rst", 32'h0000_0124);

        check("we_pulse_count", we_pulses, n_writes);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
